fir_stream_sequencer: RTL and testbench
=======================================

# fir_stream_sequencer

Flow-control sequencer in front of `fir_core`. The core consumes one `x` sample and emits one `y` sample per `*_triosy_lz` pulse and cannot stall. This block supplies the handshake the core lacks:
- buffers upstream samples in a small FIFO;
- drives the core's `x` input;
- tags every consumed sample as real or filler;
- delivers only real results on a valid/ready output;
- provides a flush sequence that clears the core delay line with zeros.

## Interface
Parameters:
- `DATA_W`, 32, sample and result width
- `FIFO_DEPTH`, 4, input FIFO entries (power of two, ≥2)
- `TAPS`, 4, number of zero samples fed during a flush
- `LAT_MAX`, 8, tag FIFO depth; must be ≥ core samples in flight (power of two)

Ports:
- `clk`  in  1  single clock, all logic rising-edge
- `rst`  in  1  asynchronous, active-high reset
- `in_vld`  in  1  upstream sample valid
- `in_rdy`  out  1  FIFO can accept
- `in_dat`  in  DATA_W  upstream sample
- `out_vld`  out  1  result valid
- `out_rdy`  in  1  downstream accepts
- `out_dat`  out  DATA_W  filtered result
- `flush_req`  in  1  one-cycle pulse; start flush
- `flush_busy`  out  1  high while flushing
- `core_x_dat`  out  DATA_W  to `fir_core x_rsc_dat`
- `core_x_lz`  in  1  from `x_triosy_lz`; sample consumed this cycle
- `core_y_dat`  in  DATA_W  from `y_rsc_dat`
- `core_y_lz`  in  1  from `y_triosy_lz`; result valid this cycle
- `ovf_err`  out  1  sticky: real result dropped
- `udf_err`  out  1  sticky: core consumed while FIFO empty in RUN
- `tag_err`  out  1  sticky: tag FIFO overflow or underflow

## Operation
- FSM states:
  - IDLE (reset state): goes to RUN when the FIFO is non-empty.
  - RUN: goes to IDLE when the FIFO is empty and `core_x_lz` pops the last entry.
  - FLUSH: goes to IDLE after `TAPS` `core_x_lz` pulses.
  - `flush_req` in any state enters FLUSH, clears the FIFO and loads the zero counter to `TAPS`. A `flush_req` during FLUSH restarts the count.
- `core_x_dat` is the FIFO head in RUN with the FIFO non-empty; 0 otherwise.
- `core_x_lz` effects:
  - RUN with FIFO non-empty: pop head, push tag 1.
  - All other cases: push tag 0.
  - RUN with FIFO empty additionally sets `udf_err`.
  - FLUSH additionally decrements the zero counter.
- `core_y_lz` pops one tag:
  - Tag 1: result is real and goes to the output register.
  - Tag 0: result is discarded.
  - Tag FIFO empty: result is discarded and `tag_err` is set.
  - Tag push while the tag FIFO is full: tag is dropped and `tag_err` is set.
- `in_rdy` = FIFO not full AND state ≠ FLUSH AND no `flush_req` this cycle.
- FIFO push and pop in the same cycle are both honoured, including when full (pop frees the slot). `in_rdy` is based on the registered full flag only.
- Output register, one entry:
  - A real result loads it when `!out_vld || out_rdy`.
  - Otherwise the new result is dropped, the old one is kept, and `ovf_err` is set.
- Tags already in flight at flush entry keep their value, so real results computed before the flush are still delivered.
- Error flags clear only on `rst`.

## Timing
- Reset values:
  - `in_rdy` 0 while `rst` is asserted, 1 in the first cycle after release.
  - 0: `out_vld`, `out_dat`, `flush_busy`, `ovf_err`, `udf_err`, `tag_err`.
  - `core_x_dat` 0; FSM in IDLE; both FIFOs empty.
- `rst` asserted mid-operation discards everything immediately; no partial flush.
- `in_vld && in_rdy` at edge N: the sample is at the FIFO head and on `core_x_dat` by edge N+1 if the FIFO was empty. The FSM enters RUN at N+1.
- `core_y_lz` at edge N with tag 1: `out_vld`=1 and `out_dat` valid after edge N.
- `flush_busy` rises the cycle after `flush_req`. It falls the cycle after the `TAPS`-th consumed zero.

## Configuration
- `FIR_SEQ_DROP_CNT_EN`:
  - Defined: adds output `drop_cnt[15:0]`, reset 0. It increments, saturating at 0xFFFF, on every `ovf_err` set event: each dropped real result, not only the first.
  - Undefined: the port and counter are absent. The sticky flags are unchanged.

## Test plan
- Push 10, 20, 30, 40 with the core consuming every cycle at latency 2 → `out_dat` 10, 20, 30, 40 in order. No error flags set.
- Core consumes 3 times before any input (IDLE) → 3 `y` pulses discarded; `out_vld` stays 0; `udf_err`=0.
- `flush_req` with 2 real samples in flight and 2 in the FIFO → 2 in-flight results delivered; FIFO entries lost. Exactly 4 zeros consumed with `flush_busy`=1 for that span, then IDLE and `in_rdy`=1.
- Hold `out_rdy`=0 across 2 real results → first result held. `ovf_err`=1; `drop_cnt`=1 when the macro is enabled.
- Fill the FIFO to 4 with the core idle → `in_rdy`=0. One `core_x_lz` with `in_vld`=1 leaves the FIFO still full with the head advanced.
- Assert `rst` mid-FLUSH → all outputs at reset values next cycle; no zeros fed after release.

Source files
------------

// File: rtl/fir_stream_sequencer.sv
// fir_stream_sequencer: flow-control wrapper around a non-stallable fir_core.
// It buffers upstream samples in a small FIFO, drives the core's x input,
// tags each consumed sample as real or filler, forwards only real results to
// a valid/ready output register, and runs a zero-fill flush of the delay line.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   in_vld/in_rdy/in_dat      upstream sample stream
//   out_vld/out_rdy/out_dat   filtered result stream (one-entry register)
//   flush_req / flush_busy    flush start pulse / flush in progress
//   core_x_dat, core_x_lz     sample to core / core consumed a sample
//   core_y_dat, core_y_lz     result from core / core result valid
//   ovf_err, udf_err, tag_err sticky error flags, cleared only by rst
//   drop_cnt                  saturating dropped-result count (optional)
//
// Build option: define FIR_SEQ_DROP_CNT_EN to add the drop_cnt output.
module fir_stream_sequencer #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TAPS       = 4,
  parameter int unsigned LAT_MAX    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_vld,
  output logic              in_rdy,
  input  logic [DATA_W-1:0] in_dat,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic [DATA_W-1:0] out_dat,
  input  logic              flush_req,
  output logic              flush_busy,
  output logic [DATA_W-1:0] core_x_dat,
  input  logic              core_x_lz,
  input  logic [DATA_W-1:0] core_y_dat,
  input  logic              core_y_lz,
  output logic              ovf_err,
  output logic              udf_err,
  output logic              tag_err
`ifdef FIR_SEQ_DROP_CNT_EN
  ,
  output logic [15:0]       drop_cnt
`endif
);

  localparam int unsigned FA_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned FC_W = FA_W + 1;
  localparam int unsigned TA_W = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;
  localparam int unsigned TC_W = TA_W + 1;
  localparam int unsigned ZC_W = $clog2(TAPS + 1) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic [ZC_W-1:0] zcnt_q, zcnt_d;

  // Input FIFO storage and bookkeeping
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [FA_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [FC_W-1:0]   cnt_q, cnt_d;
  logic              full_q;

  // Tag FIFO: one bit per sample the core has consumed, 1 = real sample
  logic [LAT_MAX-1:0] tag_mem_q;
  logic [TA_W-1:0]    twr_ptr_q, trd_ptr_q;
  logic [TC_W-1:0]    tcnt_q, tcnt_d;

  logic              out_vld_q;
  logic [DATA_W-1:0] out_dat_q;
  logic              flush_busy_q;
  logic              ovf_q, udf_q, tag_err_q;

  logic fifo_empty_c, run_c, real_pop_c, fifo_wr_c;
  logic tag_full_c, tag_empty_c, tag_pop_c, tag_push_c;
  logic real_res_c, ovf_set_c, udf_set_c, tag_err_set_c;

  assign fifo_empty_c = (cnt_q == '0);
  assign run_c        = (state_q == S_RUN);
  assign real_pop_c   = core_x_lz && run_c && !fifo_empty_c;
  // A same-cycle pop frees a slot, so a write is taken even while full_q is set.
  assign fifo_wr_c    = in_vld && !flush_req && (state_q != S_FLUSH) &&
                        (!full_q || real_pop_c);

  // Ready uses only the registered full flag; held low during reset.
  assign in_rdy     = !rst && !full_q && (state_q != S_FLUSH) && !flush_req;
  assign core_x_dat = (run_c && !fifo_empty_c) ? mem_q[rd_ptr_q] : '0;

  assign tag_full_c    = (tcnt_q == TC_W'(LAT_MAX));
  assign tag_empty_c   = (tcnt_q == '0);
  assign tag_pop_c     = core_y_lz && !tag_empty_c;
  assign tag_push_c    = core_x_lz && (!tag_full_c || tag_pop_c);
  assign tag_err_set_c = (core_y_lz && tag_empty_c) ||
                         (core_x_lz && tag_full_c && !tag_pop_c);
  assign real_res_c    = tag_pop_c && tag_mem_q[trd_ptr_q];
  assign ovf_set_c     = real_res_c && out_vld_q && !out_rdy;
  assign udf_set_c     = core_x_lz && run_c && fifo_empty_c;

  // Next occupancy of the input FIFO, ignoring a flush clear
  always_comb begin
    cnt_d = cnt_q;
    if (fifo_wr_c && !real_pop_c) begin
      cnt_d = cnt_q + FC_W'(1);
    end else if (!fifo_wr_c && real_pop_c) begin
      cnt_d = cnt_q - FC_W'(1);
    end
  end

  // Next occupancy of the tag FIFO
  always_comb begin
    tcnt_d = tcnt_q;
    if (tag_push_c && !tag_pop_c) begin
      tcnt_d = tcnt_q + TC_W'(1);
    end else if (!tag_push_c && tag_pop_c) begin
      tcnt_d = tcnt_q - TC_W'(1);
    end
  end

  // Sequencer next-state and zero counter
  always_comb begin
    state_d = state_q;
    zcnt_d  = zcnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (!fifo_empty_c) state_d = S_RUN;
      end
      S_RUN: begin
        if (cnt_d == '0) state_d = S_IDLE;
      end
      S_FLUSH: begin
        if (core_x_lz) begin
          if (zcnt_q <= ZC_W'(1)) begin
            zcnt_d  = '0;
            state_d = S_IDLE;
          end else begin
            zcnt_d = zcnt_q - ZC_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A flush request wins in every state and restarts the zero count.
    if (flush_req) begin
      state_d = S_FLUSH;
      zcnt_d  = ZC_W'(TAPS);
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      zcnt_q       <= '0;
      flush_busy_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      zcnt_q       <= zcnt_d;
      flush_busy_q <= (state_d == S_FLUSH);
    end
  end

  // Input FIFO pointers; a flush empties it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
    end else if (flush_req) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
    end else begin
      if (fifo_wr_c)  wr_ptr_q <= wr_ptr_q + FA_W'(1);
      if (real_pop_c) rd_ptr_q <= rd_ptr_q + FA_W'(1);
      cnt_q  <= cnt_d;
      full_q <= (cnt_d == FC_W'(FIFO_DEPTH));
    end
  end

  // Input FIFO data; contents are only observed through valid entries
  always_ff @(posedge clk) begin
    if (fifo_wr_c) mem_q[wr_ptr_q] <= in_dat;
  end

  // Tag FIFO; kept across a flush so in-flight real results still emerge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_mem_q <= '0;
      twr_ptr_q <= '0;
      trd_ptr_q <= '0;
      tcnt_q    <= '0;
    end else begin
      if (tag_push_c) begin
        tag_mem_q[twr_ptr_q] <= real_pop_c;
        twr_ptr_q            <= twr_ptr_q + TA_W'(1);
      end
      if (tag_pop_c) trd_ptr_q <= trd_ptr_q + TA_W'(1);
      tcnt_q <= tcnt_d;
    end
  end

  // One-entry output register; a result arriving while it is blocked is lost
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld_q <= 1'b0;
      out_dat_q <= '0;
    end else if (real_res_c && (!out_vld_q || out_rdy)) begin
      out_vld_q <= 1'b1;
      out_dat_q <= core_y_dat;
    end else if (out_rdy) begin
      out_vld_q <= 1'b0;
    end
  end

  // Sticky error flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
      tag_err_q <= 1'b0;
    end else begin
      if (ovf_set_c)     ovf_q     <= 1'b1;
      if (udf_set_c)     udf_q     <= 1'b1;
      if (tag_err_set_c) tag_err_q <= 1'b1;
    end
  end

`ifdef FIR_SEQ_DROP_CNT_EN
  logic [15:0] drop_cnt_q;

  // Counts every dropped real result, saturating
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt_q <= '0;
    end else if (ovf_set_c && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign drop_cnt = drop_cnt_q;
`else
  // No drop counter; ovf_err alone records dropped results.
`endif

  assign out_vld    = out_vld_q;
  assign out_dat    = out_dat_q;
  assign flush_busy = flush_busy_q;
  assign ovf_err    = ovf_q;
  assign udf_err    = udf_q;
  assign tag_err    = tag_err_q;

endmodule

// File: tb/tb_fir_stream_sequencer.sv
// Bench for fir_stream_sequencer: an emulated fir_core (identity filter,
// latency 2), a queue-based reference model checked every cycle, and
// directed scenarios with literal expected results.
module tb_fir_stream_sequencer;

  localparam int unsigned DW = 32;
  localparam int unsigned FD = 4;
  localparam int unsigned TP = 4;
  localparam int unsigned LM = 8;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_FLUSH = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_vld = 1'b0;
  logic [DW-1:0] in_dat = '0;
  logic          out_rdy = 1'b1;
  logic          flush_req = 1'b0;
  logic          core_x_lz = 1'b0;
  logic          core_y_lz = 1'b0;
  logic [DW-1:0] core_y_dat = '0;
  logic          in_rdy, out_vld, flush_busy, ovf_err, udf_err, tag_err;
  logic [DW-1:0] out_dat, core_x_dat;
`ifdef FIR_SEQ_DROP_CNT_EN
  logic [15:0]   drop_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  fir_stream_sequencer #(
    .DATA_W(DW), .FIFO_DEPTH(FD), .TAPS(TP), .LAT_MAX(LM)
  ) dut (
    .clk(clk), .rst(rst),
    .in_vld(in_vld), .in_rdy(in_rdy), .in_dat(in_dat),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_dat(out_dat),
    .flush_req(flush_req), .flush_busy(flush_busy),
    .core_x_dat(core_x_dat), .core_x_lz(core_x_lz),
    .core_y_dat(core_y_dat), .core_y_lz(core_y_lz),
    .ovf_err(ovf_err), .udf_err(udf_err), .tag_err(tag_err)
`ifdef FIR_SEQ_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Emulated core: consumes while core_en is set, echoes x as y two cycles later
  logic          core_en = 1'b0;
  logic          cap_v = 1'b0, p1_v = 1'b0, p2_v = 1'b0;
  logic [DW-1:0] cap_d = '0, p1_d = '0, p2_d = '0;

  always @(negedge clk) begin
    cap_v = core_x_lz;
    cap_d = core_x_dat;
  end

  always @(posedge clk) begin
    #2;
    if (rst) begin
      p1_v = 1'b0; p2_v = 1'b0; p1_d = '0; p2_d = '0;
    end else begin
      p2_v = p1_v; p2_d = p1_d;
      p1_v = cap_v; p1_d = cap_d;
    end
    core_y_lz  = p2_v;
    core_y_dat = p2_d;
    core_x_lz  = core_en && !rst;
  end

  // Reference model: sample queue, tag queue, mode, zeros left
  logic [DW-1:0] mq[$];
  bit            tq[$];
  int            mode = M_IDLE;
  int            zl = 0;
  logic          m_ov = 1'b0, m_ovf = 1'b0, m_udf = 1'b0, m_tag = 1'b0;
  logic [DW-1:0] m_od = '0;
  logic [15:0]   m_drop = '0;

  always @(posedge clk) begin : model
    int pre;
    bit t, realr;
    if (rst) begin
      mq.delete(); tq.delete();
      mode = M_IDLE; zl = 0;
      m_ov = 0; m_od = '0; m_ovf = 0; m_udf = 0; m_tag = 0; m_drop = '0;
    end else begin
      pre = mq.size();
      t = 0; realr = 0;
      if (core_x_lz) begin
        if (mode == M_RUN && mq.size() > 0) begin
          void'(mq.pop_front());
          t = 1;
        end else if (mode == M_RUN) begin
          m_udf = 1;
        end
        if (mode == M_FLUSH && zl > 0) zl--;
      end
      if (core_y_lz) begin
        if (tq.size() == 0) m_tag = 1;
        else realr = tq.pop_front();
      end
      if (core_x_lz) begin
        if (tq.size() >= LM) m_tag = 1;
        else tq.push_back(t);
      end
      if (realr) begin
        if (!m_ov || out_rdy) begin
          m_ov = 1; m_od = core_y_dat;
        end else begin
          m_ovf = 1;
          if (m_drop != 16'hFFFF) m_drop++;
        end
      end else if (out_rdy) begin
        m_ov = 0;
      end
      if (in_vld && !flush_req && mode != M_FLUSH && mq.size() < FD) mq.push_back(in_dat);
      if (flush_req) begin
        mode = M_FLUSH; mq.delete(); zl = TP;
      end else if (mode == M_IDLE) begin
        if (pre > 0) mode = M_RUN;
      end else if (mode == M_RUN) begin
        if (mq.size() == 0) mode = M_IDLE;
      end else if (zl == 0) begin
        mode = M_IDLE;
      end
    end
  end

  // Per-cycle compare against the model, plus capture of delivered results
  logic [DW-1:0] got[$];

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_in_rdy", in_rdy, 0);
      chk("rst_out_vld", out_vld, 0);
      chk("rst_out_dat", out_dat, 0);
      chk("rst_flush_busy", flush_busy, 0);
      chk("rst_core_x_dat", core_x_dat, 0);
      chk("rst_errs", {ovf_err, udf_err, tag_err}, 0);
    end else begin
      chk("in_rdy", in_rdy, (mq.size() < FD && mode != M_FLUSH && !flush_req));
      chk("core_x_dat", core_x_dat, (mode == M_RUN && mq.size() > 0) ? mq[0] : '0);
      chk("out_vld", out_vld, m_ov);
      chk("out_dat", out_dat, m_od);
      chk("flush_busy", flush_busy, mode == M_FLUSH);
      chk("ovf_err", ovf_err, m_ovf);
      chk("udf_err", udf_err, m_udf);
      chk("tag_err", tag_err, m_tag);
`ifdef FIR_SEQ_DROP_CNT_EN
      chk("drop_cnt", drop_cnt, m_drop);
`endif
      if (out_vld && out_rdy) got.push_back(out_dat);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] d);
    in_vld = 1'b1;
    in_dat = d;
    step();
    in_vld = 1'b0;
  endtask

  task automatic chk_got(input string nm, input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                         input logic [DW-1:0] e2, input logic [DW-1:0] e3,
                         input logic [DW-1:0] e4, input int n);
    logic [DW-1:0] ev [5];
    ev = '{e0, e1, e2, e3, e4};
    chk({nm, "_count"}, 32'(got.size()), 32'(n));
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_%0d", nm, i), (i < got.size()) ? got[i] : 32'hDEADBEEF, ev[i]);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int busy, zeros;
    repeat (3) step();
    rst = 1'b0;
    mid();
    chk("lit_in_rdy_after_rst", in_rdy, 1);
    chk("lit_core_x_dat_after_rst", core_x_dat, 0);

    // Four samples, core consuming every cycle
    step();
    core_en = 1'b1;
    out_rdy = 1'b1;
    push(10); push(20); push(30); push(40);
    repeat (8) step();
    core_en = 1'b0;
    repeat (4) step();
    mid();
    chk_got("A_out", 10, 20, 30, 40, 0, 4);
    chk("A_errs", {ovf_err, udf_err, tag_err}, 0);

    // Core consumes in IDLE with nothing queued: fillers only
    step();
    got.delete();
    core_en = 1'b1;
    repeat (3) step();
    core_en = 1'b0;
    repeat (5) step();
    mid();
    chk("B_delivered", 32'(got.size()), 0);
    chk("B_out_vld", out_vld, 0);
    chk("B_udf", udf_err, 0);

    // Flush with two real samples in flight and two queued
    step();
    got.delete();
    push(1); push(2); push(3); push(4);
    core_en = 1'b1;
    repeat (2) step();
    core_en = 1'b0;
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    core_en = 1'b1;
    busy = 0; zeros = 0;
    repeat (8) begin
      @(negedge clk);
      if (flush_busy) busy++;
      if (flush_busy && core_x_lz) zeros++;
    end
    @(posedge clk); #1;
    core_en = 1'b0;
    repeat (4) step();
    mid();
    chk("C_busy_cycles", 32'(busy), 4);
    chk("C_zeros", 32'(zeros), 4);
    chk_got("C_out", 1, 2, 0, 0, 0, 2);
    chk("C_in_rdy", in_rdy, 1);
    chk("C_flush_busy", flush_busy, 0);

    // Output blocked across two real results
    step();
    got.delete();
    out_rdy = 1'b0;
    core_en = 1'b1;
    push(7); push(8);
    repeat (6) step();
    mid();
    chk("D_out_vld", out_vld, 1);
    chk("D_out_dat", out_dat, 7);
    chk("D_ovf", ovf_err, 1);
`ifdef FIR_SEQ_DROP_CNT_EN
    chk("D_drop_cnt", drop_cnt, 1);
`endif
    step();
    out_rdy = 1'b1;
    repeat (2) step();
    core_en = 1'b0;
    repeat (3) step();
    mid();
    chk_got("D_out", 7, 0, 0, 0, 0, 1);
    chk("D_out_vld_after", out_vld, 0);

    // Fill the FIFO, then one consume with a simultaneous write
    step();
    got.delete();
    push(50); push(51); push(52); push(53);
    mid();
    chk("E_in_rdy_full", in_rdy, 0);
    step();
    in_vld = 1'b1;
    in_dat = 54;
    core_en = 1'b1;
    step();
    in_vld = 1'b0;
    core_en = 1'b0;
    mid();
    chk("E_in_rdy_still_full", in_rdy, 0);
    chk("E_head", core_x_dat, 51);
    step();
    core_en = 1'b1;
    repeat (10) step();
    core_en = 1'b0;
    repeat (4) step();
    mid();
    chk_got("E_out", 50, 51, 52, 53, 54, 5);

    // Reset in the middle of a flush
    step();
    push(5); push(6);
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    core_en = 1'b1;
    repeat (2) step();
    rst = 1'b1;
    mid();
    chk("F_rst_busy", flush_busy, 0);
    chk("F_rst_out_vld", out_vld, 0);
    chk("F_rst_ovf", ovf_err, 0);
    chk("F_rst_in_rdy", in_rdy, 0);
    step();
    rst = 1'b0;
    busy = 0;
    repeat (6) begin
      @(negedge clk);
      if (flush_busy || core_x_dat != '0) busy++;
    end
    @(posedge clk); #1;
    core_en = 1'b0;
    repeat (3) step();
    mid();
    chk("F_no_zero_feed", 32'(busy), 0);
    chk("F_in_rdy", in_rdy, 1);
    chk("F_errs", {ovf_err, udf_err, tag_err}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
